// File: rtl/hazard_sched.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use/branch
// stalls, decode/execute flushes, and a data-memory wait FSM with timeout.
module hazard_sched #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             PCSrcD,
  input  logic             memreqM,
  input  logic             memreadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             memerr,
  output logic [CNT_W-1:0] stallcnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {RUN = 2'd0, MWAIT = 2'd1, MERR = 2'd2} state_t;

  state_t     state, state_nx;
  logic [7:0] waitcnt, waitcnt_nx;
  logic       miss, memstall, lwstall, branchstall, hazstall;

  // Register match that ignores r0, which never carries a dependency.
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // Memory handshake: memreqM marks an access in M; the access completes in
  // any cycle where memreadyM is high. Request without ready is a miss.
  assign miss = memreqM & ~memreadyM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      waitcnt  <= 8'd0;
      memerr   <= 1'b0;
      stallcnt <= '0;
    end else begin
      state   <= state_nx;
      waitcnt <= waitcnt_nx;
      if (state_nx == MERR) memerr <= 1'b1;
      if (stallF && (stallcnt != {CNT_W{1'b1}})) stallcnt <= stallcnt + 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    waitcnt_nx = waitcnt;
    memstall   = 1'b0;
    case (state)
      RUN: begin
        memstall = miss;
        if (miss) begin
          state_nx   = MWAIT;
          waitcnt_nx = 8'd1;
        end
      end
      MWAIT: begin
        memstall = miss;
        if (!miss) begin
          state_nx   = RUN;
          waitcnt_nx = 8'd0;
        end else if (waitcnt == 8'(MEM_TIMEOUT)) begin
          state_nx = MERR;
        end else begin
          waitcnt_nx = waitcnt + 8'd1;
        end
      end
      MERR: begin
        state_nx   = RUN;
        waitcnt_nx = 8'd0;
      end
      default: begin
        state_nx   = RUN;
        waitcnt_nx = 8'd0;
      end
    endcase
  end

  assign lwstall     = memtoregE & regwriteE & (hit(writeregE, rsD) | hit(writeregE, rtD));
  assign branchstall = branchD &
                       ((regwriteE & (hit(writeregE, rsD) | hit(writeregE, rtD))) |
                        (memtoregM & (hit(writeregM, rsD) | hit(writeregM, rtD))));
  assign hazstall    = lwstall | branchstall;

  // All controls are held inactive while reset is asserted.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (reset) begin
      stallE    = memstall;
      stallM    = memstall;
      stallF    = memstall | hazstall;
      stallD    = memstall | hazstall;
      flushE    = hazstall & ~memstall;
      flushD    = PCSrcD & ~hazstall & ~memstall;
      forwardAD = regwriteM & hit(writeregM, rsD);
      forwardBD = regwriteM & hit(writeregM, rtD);
      if (regwriteM && hit(writeregM, rsE))      forwardAE = 2'b10;
      else if (regwriteW && hit(writeregW, rsE)) forwardAE = 2'b01;
      if (regwriteM && hit(writeregM, rtE))      forwardBE = 2'b10;
      else if (regwriteW && hit(writeregW, rtE)) forwardBE = 2'b01;
    end
  end

  assign dbg_state = state;

endmodule
